rr_decode_arbiter: RTL and testbench

//   Round-robin arbiter for 8 requesters sharing one resource. Each cycle it

---
 rtl/rr_decode_arbiter.sv | 135 +++++++++++++
 tb/tb_rr_decode_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for eight requesters. The winner is held while it keeps requesting,
// up to MAX_HOLD cycles. The grant leaves as a registered one-hot decode of the winner index.
module rr_decode_arbiter #(
    parameter int unsigned NUM_REQ  = 8,
    parameter int unsigned IDX_W    = 3,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arb_en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               timeout
);

    localparam int unsigned HC_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0] HC_MAX = HC_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_PARK  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   ptr_nxt;
    logic [HC_W-1:0]    hold_cnt;
    logic [HC_W-1:0]    hold_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [IDX_W-1:0]   gnt_idx_nxt;
    logic               gnt_valid_nxt;
    logic               timeout_nxt;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;
    logic               holder_req;
    logic               hold_expired;

    // First requester at or above ptr, wrapping from the top index to 0
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign holder_req   = req[gnt_idx];
    assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HC_MAX);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
            gnt       <= gnt_nxt;
            gnt_idx   <= gnt_idx_nxt;
            gnt_valid <= gnt_valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

    // Next-state logic; a release takes priority over a timeout on the same edge
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_PARK: begin
                if (arb_en && win_found) begin
                    state_nxt = S_GRANT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_GRANT: begin
                if (!holder_req || hold_expired) begin
                    state_nxt = S_PARK;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values for the output, pointer and hold-counter registers
    always_comb begin
        ptr_nxt       = ptr;
        hold_nxt      = '0;
        gnt_idx_nxt   = gnt_idx;
        gnt_nxt       = '0;
        gnt_valid_nxt = 1'b0;
        timeout_nxt   = 1'b0;
        case (state_nxt)
            S_GRANT: begin
                if (state != S_GRANT) begin
                    gnt_idx_nxt = win_idx;
                    ptr_nxt     = win_idx + IDX_W'(1);
                    hold_nxt    = HC_W'(1);
                end else if (hold_cnt != '1) begin
                    hold_nxt = hold_cnt + HC_W'(1);
                end else begin
                    hold_nxt = hold_cnt;
                end
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    gnt_nxt[i] = (gnt_idx_nxt == IDX_W'(i));
                end
                gnt_valid_nxt = 1'b1;
            end
            S_PARK: begin
                // PARK is only entered from GRANT; a still-requesting holder was preempted
                timeout_nxt = holder_req;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed bench for rr_decode_arbiter with MAX_HOLD=4. It covers async reset, a single
// holder, the timeout rotation, pointer wrap, arb_en gating and release/timeout overlap.
module tb_rr_decode_arbiter;

    logic       clk;
    logic       rst_n;
    logic       arb_en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    rr_decode_arbiter #(
        .NUM_REQ  (8),
        .IDX_W    (3),
        .MAX_HOLD (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arb_en    (arb_en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected outputs: v=grant valid, idx=holder (checked only when v), to=timeout
    task automatic exp_out(input string tag, input bit v, input int idx, input bit to);
        logic [7:0] g;
        g = v ? (8'd1 << idx) : 8'd0;
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        chk({tag, ".valid"}, 32'(gnt_valid), 32'(v));
        if (v) chk({tag, ".idx"}, 32'(gnt_idx), 32'(idx));
        chk({tag, ".timeout"}, 32'(timeout), 32'(to));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        req    = 8'h00;
        arb_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = 8'h00;
        arb_en = 1'b1;

        // 1: async reset mid-grant, then the pointer restarts at 0
        do_reset();
        exp_out("t1.reset", 0, 0, 0);
        chk("t1.reset.idx", 32'(gnt_idx), 32'd0);
        req = 8'h10;
        tick();
        exp_out("t1.g4", 1, 4, 0);
        req = 8'hFF;
        tick();
        exp_out("t1.hold4", 1, 4, 0);
        #2 rst_n = 1'b0;
        #1;
        exp_out("t1.async", 0, 0, 0);
        chk("t1.async.idx", 32'(gnt_idx), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        exp_out("t1.first", 1, 0, 0);

        // 2: single requester held for three cycles, then released
        do_reset();
        req = 8'h20;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_out($sformatf("t2.g%0d", k), 1, 5, 0);
        end
        req = 8'h00;
        tick();
        exp_out("t2.park", 0, 0, 0);
        chk("t2.park.idx_kept", 32'(gnt_idx), 32'd5);
        tick();
        exp_out("t2.idle", 0, 0, 0);

        // 3: all requesting; four cycles each, then a PARK cycle with timeout
        do_reset();
        req = 8'hFF;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (((k - 1) % 5) < 4) exp_out($sformatf("t3.c%0d", k), 1, ((k - 1) / 5) % 8, 0);
            else                   exp_out($sformatf("t3.c%0d", k), 0, 0, 1);
        end
        req = 8'h00;
        tick();
        exp_out("t3.idle", 0, 0, 0);

        // 4: pointer at 7 serves idx 7 before wrapping to idx 0
        do_reset();
        req = 8'h40;
        tick();
        exp_out("t4.g6", 1, 6, 0);
        req = 8'h00;
        tick();
        tick();
        req = 8'h81;
        tick();
        exp_out("t4.g7", 1, 7, 0);
        req = 8'h01;
        tick();
        exp_out("t4.park", 0, 0, 0);
        tick();
        exp_out("t4.g0", 1, 0, 0);
        req = 8'h00;
        tick();
        tick();

        // 5: arb_en=0 keeps the holder but blocks new grants
        do_reset();
        req = 8'h04;
        tick();
        exp_out("t5.g2", 1, 2, 0);
        arb_en = 1'b0;
        req    = 8'h0C;
        tick();
        exp_out("t5.keep_a", 1, 2, 0);
        tick();
        exp_out("t5.keep_b", 1, 2, 0);
        req = 8'h08;
        tick();
        exp_out("t5.park", 0, 0, 0);
        tick();
        exp_out("t5.blocked_a", 0, 0, 0);
        tick();
        exp_out("t5.blocked_b", 0, 0, 0);
        arb_en = 1'b1;
        tick();
        exp_out("t5.g3", 1, 3, 0);
        req = 8'h00;
        tick();
        tick();

        // 6: release on the fourth grant cycle is a plain release, not a timeout
        do_reset();
        req = 8'h02;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_out($sformatf("t6.g%0d", k), 1, 1, 0);
        end
        req = 8'h00;
        tick();
        exp_out("t6.park", 0, 0, 0);
        tick();
        exp_out("t6.idle", 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
